// File: rtl/reg_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Architectural register file with per-register ROB rename tags
//               and two combinational source-operand query ports.
//               Optional macro REG_FILE_BYPASS_EN enables same-cycle
//               commit-to-query forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
  parameter int ROB_SIZE_BIT = 5,
  parameter int REG_NUM      = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    is_update_val,
  input  logic [4:0]              update_val_id,
  input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
  input  logic [31:0]             update_val,
  input  logic                    is_update_dep,
  input  logic [4:0]              update_dep_id,
  input  logic [ROB_SIZE_BIT-1:0] update_dep,
  input  logic [4:0]              qry1_reg_id,
  output logic                    qry1_busy,
  output logic [ROB_SIZE_BIT-1:0] qry1_dep,
  output logic [31:0]             qry1_value,
  input  logic [4:0]              qry2_reg_id,
  output logic                    qry2_busy,
  output logic [ROB_SIZE_BIT-1:0] qry2_dep,
  output logic [31:0]             qry2_value
);

  localparam int QRY_W = 1 + ROB_SIZE_BIT + 32;

  logic [31:0]             values [REG_NUM];
  logic [REG_NUM-1:0]      busy;
  logic [ROB_SIZE_BIT-1:0] tags   [REG_NUM];

  // Entry 0 is only ever reset, so x0 stays zero and never busy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        values[i] <= '0;
        tags[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (rob_clear) begin
        busy <= '0;
        for (int i = 0; i < REG_NUM; i++) begin
          tags[i] <= '0;
        end
      end else begin
        for (int i = 1; i < REG_NUM; i++) begin
          if (is_update_val && update_val_id == 5'(i)) begin
            values[i] <= update_val;
          end
          // A same-cycle rename wins over the commit's busy clear.
          if (is_update_dep && update_dep_id == 5'(i)) begin
            busy[i] <= 1'b1;
            tags[i] <= update_dep;
          end else if (is_update_val && update_val_id == 5'(i) &&
                       busy[i] && tags[i] == update_val_dep) begin
            busy[i] <= 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [QRY_W-1:0] lookup(input logic [4:0] id);
    logic                    b;
    logic [ROB_SIZE_BIT-1:0] d;
    logic [31:0]             v;
    b = busy[id];
    d = tags[id];
    v = values[id];
`ifdef REG_FILE_BYPASS_EN
    if (is_update_val && id != 5'd0 && update_val_id == id &&
        b && d == update_val_dep) begin
      b = 1'b0;
      v = update_val;
    end
`endif
    if (!b) d = '0;
    if (b)  v = '0;
    return {b, d, v};
  endfunction

  always_comb begin
    {qry1_busy, qry1_dep, qry1_value} = lookup(qry1_reg_id);
    {qry2_busy, qry2_dep, qry2_value} = lookup(qry2_reg_id);
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Scoreboard testbench for reg_file (honours REG_FILE_BYPASS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_clear = 1'b0;
  logic        is_update_val = 1'b0;
  logic [4:0]  update_val_id = '0;
  logic [4:0]  update_val_dep = '0;
  logic [31:0] update_val = '0;
  logic        is_update_dep = 1'b0;
  logic [4:0]  update_dep_id = '0;
  logic [4:0]  update_dep = '0;
  logic [4:0]  qry1_reg_id = '0;
  logic        qry1_busy;
  logic [4:0]  qry1_dep;
  logic [31:0] qry1_value;
  logic [4:0]  qry2_reg_id = '0;
  logic        qry2_busy;
  logic [4:0]  qry2_dep;
  logic [31:0] qry2_value;

  always #5 clk_in = ~clk_in;

  reg_file #(.ROB_SIZE_BIT(5), .REG_NUM(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .is_update_val(is_update_val), .update_val_id(update_val_id),
    .update_val_dep(update_val_dep), .update_val(update_val),
    .is_update_dep(is_update_dep), .update_dep_id(update_dep_id), .update_dep(update_dep),
    .qry1_reg_id(qry1_reg_id), .qry1_busy(qry1_busy), .qry1_dep(qry1_dep), .qry1_value(qry1_value),
    .qry2_reg_id(qry2_reg_id), .qry2_busy(qry2_busy), .qry2_dep(qry2_dep), .qry2_value(qry2_value)
  );

  typedef struct {
    string       name;
    logic [4:0]  id1;
    logic [4:0]  id2;
    logic [37:0] exp1;
    logic [37:0] exp2;
  } entry_t;

  entry_t      sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_val [32];

  function automatic logic [37:0] mk(input logic b, input logic [4:0] d, input logic [31:0] v);
    return {b, d, v};
  endfunction

  task automatic push(input string n, input logic [4:0] id, input logic [37:0] e);
    sb.push_back('{n, id, id, e, e});
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    is_update_val = 1'b0;
    is_update_dep = 1'b0;
    rob_clear     = 1'b0;
  endtask

  task automatic test_reset();
    entry_t e;
    logic [37:0] o1, o2;
    for (int i = 0; i < 32; i++) model_val[i] = '0;
    #1 rst_n_in = 1'b0;
    #1;
    push("reset_x1", 5'd1, mk(0, 0, 0));
    push("reset_x17", 5'd17, mk(0, 0, 0));
    push("reset_x31", 5'd31, mk(0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
    cycle();
    rst_n_in = 1'b1;
  endtask

  task automatic test_rename_commit();
    entry_t e;
    logic [37:0] o1, o2;
    cycle();
    is_update_dep = 1; update_dep_id = 5'd5; update_dep = 5'd3;
    cycle(); idle();
    push("rc_renamed", 5'd5, mk(1, 3, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
    cycle();
    is_update_val = 1; update_val_id = 5'd5; update_val_dep = 5'd3; update_val = 32'hDEADBEEF;
`ifdef REG_FILE_BYPASS_EN
    push("rc_same_cycle", 5'd5, mk(0, 0, 32'hDEADBEEF));
`else
    push("rc_same_cycle", 5'd5, mk(1, 3, 0));
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
    cycle(); idle();
    model_val[5] = 32'hDEADBEEF;
    push("rc_committed", 5'd5, mk(0, 0, model_val[5]));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
  endtask

  task automatic test_stale();
    entry_t e;
    logic [37:0] o1, o2;
    cycle();
    is_update_dep = 1; update_dep_id = 5'd7; update_dep = 5'd2;
    cycle();
    update_dep = 5'd4;
    cycle(); idle();
    is_update_val = 1; update_val_id = 5'd7; update_val_dep = 5'd2; update_val = 32'd11;
    push("stale_same_cycle", 5'd7, mk(1, 4, 0));
    cycle(); idle();
    model_val[7] = 32'd11;
    push("stale_after", 5'd7, mk(1, 4, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
    cycle();
    is_update_val = 1; update_val_id = 5'd7; update_val_dep = 5'd4; update_val = 32'd22;
    cycle(); idle();
    model_val[7] = 32'd22;
    push("stale_final", 5'd7, mk(0, 0, model_val[7]));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
  endtask

  task automatic test_simultaneous();
    entry_t e;
    logic [37:0] o1, o2;
    cycle();
    is_update_dep = 1; update_dep_id = 5'd9; update_dep = 5'd1;
    cycle();
    update_dep = 5'd6;
    is_update_val = 1; update_val_id = 5'd9; update_val_dep = 5'd1; update_val = 32'd5;
`ifdef REG_FILE_BYPASS_EN
    push("simul_same_cycle", 5'd9, mk(0, 0, 32'd5));
`else
    push("simul_same_cycle", 5'd9, mk(1, 1, 0));
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
    cycle(); idle();
    model_val[9] = 32'd5;
    push("simul_after", 5'd9, mk(1, 6, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
  endtask

  task automatic test_x0_stall();
    entry_t e;
    logic [37:0] o1, o2;
    cycle();
    is_update_dep = 1; update_dep_id = 5'd0; update_dep = 5'd3;
    is_update_val = 1; update_val_id = 5'd0; update_val_dep = 5'd3; update_val = 32'h1234;
    push("x0_same_cycle", 5'd0, mk(0, 0, 0));
    cycle(); idle();
    push("x0_after", 5'd0, mk(0, 0, 0));
    is_update_val = 1; update_val_id = 5'd4; update_val_dep = 5'd0; update_val = 32'h44;
    cycle(); idle();
    model_val[4] = 32'h44;
    rdy_in = 1'b0;
    is_update_val = 1; update_val_id = 5'd4; update_val_dep = 5'd0; update_val = 32'h99;
    is_update_dep = 1; update_dep_id = 5'd6; update_dep = 5'd2;
    cycle();
    push("stall_live_x4", 5'd4, mk(0, 0, model_val[4]));
    cycle(); idle();
    rdy_in = 1'b1;
    cycle();
    push("stall_x4_kept", 5'd4, mk(0, 0, model_val[4]));
    push("stall_x6_not_renamed", 5'd6, mk(0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
  endtask

  task automatic test_flush();
    entry_t e;
    logic [37:0] o1, o2;
    for (int i = 1; i < 32; i++) begin
      cycle();
      is_update_dep = 1; update_dep_id = 5'(i); update_dep = 5'(i);
    end
    cycle(); idle();
    push("flush_pre_x1", 5'd1, mk(1, 1, 0));
    push("flush_pre_x20", 5'd20, mk(1, 20, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
    cycle();
    rob_clear = 1;
    is_update_dep = 1; update_dep_id = 5'd3; update_dep = 5'd8;
    is_update_val = 1; update_val_id = 5'd12; update_val_dep = 5'd12; update_val = 32'h55;
    cycle(); idle();
    for (int i = 1; i < 32; i++) begin
      push($sformatf("flush_x%0d", i), 5'(i), mk(0, 0, model_val[i]));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
  endtask

  task automatic test_dual_port();
    entry_t e;
    logic [37:0] o1, o2;
    cycle();
    // Dispatch renames x5 this cycle; its own source lookup still sees the old mapping.
    is_update_dep = 1; update_dep_id = 5'd5; update_dep = 5'd17;
    sb.push_back('{"dual_5_7", 5'd5, 5'd7, mk(0, 0, model_val[5]), mk(0, 0, model_val[7])});
    sb.push_back('{"dual_9_4", 5'd9, 5'd4, mk(0, 0, model_val[9]), mk(0, 0, model_val[4])});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
    cycle(); idle();
    sb.push_back('{"dual_renamed", 5'd5, 5'd7, mk(1, 17, 0), mk(0, 0, model_val[7])});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
  endtask

  task automatic test_async_reset();
    entry_t e;
    logic [37:0] o1, o2;
    cycle();
    is_update_dep = 1; update_dep_id = 5'd10; update_dep = 5'd7;
    cycle(); idle();
    push("areset_pre_x10", 5'd10, mk(1, 7, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
    #1 rst_n_in = 1'b0;
    qry1_reg_id = 5'd5; qry2_reg_id = 5'd10; #1;
    checks += 1;
    if ({qry1_busy, qry1_value, qry2_busy, qry2_dep} !== '0) begin
      failures++;
      $display("FAIL areset_immediate got=%h exp=0", {qry1_busy, qry1_value, qry2_busy, qry2_dep});
    end
    for (int i = 1; i < 32; i++) push($sformatf("areset_x%0d", i), 5'(i), mk(0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      qry1_reg_id = e.id1; qry2_reg_id = e.id2; #1;
      o1 = {qry1_busy, qry1_dep, qry1_value}; o2 = {qry2_busy, qry2_dep, qry2_value};
      checks += 2;
      if (o1 !== e.exp1) begin failures++; $display("FAIL %s port1 got=%h exp=%h", e.name, o1, e.exp1); end
      if (o2 !== e.exp2) begin failures++; $display("FAIL %s port2 got=%h exp=%h", e.name, o2, e.exp2); end
    end
    cycle();
    rst_n_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_stale();
    test_simultaneous();
    test_x0_stall();
    test_flush();
    test_dual_port();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags.
- Sits directly downstream of the reorder buffer's commit and rename outputs, and upstream of the decoder/dispatch operand lookup.
- Holds 32 committed 32-bit values plus, per register, a busy bit and the ROB id of the youngest in-flight producer.
- Answers two combinational source-operand queries per cycle and flushes all tags on pipeline clear.

Parameters:
- ROB_SIZE_BIT, 5, width of ROB id tags (ROB holds 2^ROB_SIZE_BIT entries).
- REG_NUM, 32, number of architectural registers; index width fixed at 5.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global stall; state frozen when low
- rob_clear  input  1  mispredict flush from ROB
- is_update_val  input  1  commit write strobe
- update_val_id  input  5  committed rd
- update_val_dep  input  ROB_SIZE_BIT  ROB id of committing entry
- update_val  input  32  committed value
- is_update_dep  input  1  rename strobe from dispatch
- update_dep_id  input  5  renamed rd
- update_dep  input  ROB_SIZE_BIT  ROB id now producing rd
- qry1_reg_id  input  5  source register 1
- qry1_busy  output  1  rs1 awaits ROB result
- qry1_dep  output  ROB_SIZE_BIT  producer ROB id when busy, else 0
- qry1_value  output  32  committed value when not busy, else 0
- qry2_reg_id, qry2_busy, qry2_dep, qry2_value  same as port 1, for rs2

Behaviour:
- Reset (rst_n_in low, asynchronous): all values 0, all busy 0, all tags 0. Outputs are combinational, so each query returns busy=0, dep=0, value=0.
- rdy_in low: no state change. Query outputs stay valid against current state.
- x0: the value stays 0 and busy stays 0. Writes and renames targeting register 0 are ignored. Queries of register 0 return busy=0, value=0.
- Commit (is_update_val, rd!=0, not rob_clear):
  - value[rd] <= update_val unconditionally.
  - busy[rd] <= 0 only if busy[rd] && tag[rd]==update_val_dep, and there is no same-cycle rename of the same rd.
- Rename (is_update_dep, rd!=0, not rob_clear): busy[rd] <= 1 and tag[rd] <= update_dep.
  - Rename takes priority over a same-cycle commit's busy clear. The commit still writes the value.
- Commit whose tag mismatches (register already renamed younger): the value is written and busy/tag are unchanged.
- rob_clear high (one cycle): all busy <= 0 and tags <= 0. Same-cycle rename and commit are ignored. Values are retained.
- Queries are combinational and reflect state after same-cycle commit bypass, but before the same-cycle rename. The rename belongs to the instruction being dispatched, so its own sources see the old mapping.
- Bypass rule (see Optional Feature): if is_update_val && update_val_id==qry_reg_id!=0 && busy && tag==update_val_dep, the query returns busy=0 and value=update_val.
- Otherwise a query returns the stored busy, tag and value. dep is forced to 0 when not busy. value is forced to 0 when busy.
- Both query ports are independent and may name the same register.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: same-cycle commit-to-query forwarding as in Behaviour.
- Undefined: queries reflect registered state only. A register whose producer commits this cycle reads busy=1 with the old tag. The consumer then resolves the operand via the ROB query path.
- Commit and rename register updates are identical either way.

Test Plan:
- Reset: drive rst_n_in low mid-run with busy regs → all queries of regs 1..31 read busy=0, value=0 immediately, before any clock edge.
- Rename then commit:
  - Rename x5→tag 3; next cycle qry1=x5 → busy=1, dep=3.
  - Commit x5 tag 3 value 0xDEADBEEF → same cycle, with BYPASS_EN: busy=0, value=0xDEADBEEF; without BYPASS_EN: busy=1, dep=3. Next cycle: busy=0, value=0xDEADBEEF.
- Stale commit:
  - Rename x7→tag 2, then x7→tag 4. Commit x7 tag 2 value 11 → x7 busy=1, dep=4, stored value 11.
  - Commit tag 4 value 22 → busy=0, value 22.
- Simultaneous: x9 busy tag 1. In one cycle commit x9 tag 1 value 5 and rename x9→tag 6 → next cycle busy=1, dep=6. The same-cycle query returns the bypass value 5 (with BYPASS_EN).
- Flush: regs x1..x31 renamed, then pulse rob_clear together with a rename x3→tag 8 → next cycle all busy=0, prior committed values intact, x3 not busy.
- x0 and stall:
  - Rename/commit x0 value 0x1234 → qry x0 value 0, busy 0.
  - With rdy_in=0, a commit of x4 is not applied; after rdy_in=1 and no commit, x4 is unchanged.
